// File: rtl/systolic_pkg.sv
// Shared types and constants for the 3x3 systolic operand feeder.
package systolic_pkg;

  localparam int unsigned N          = 3;
  localparam int unsigned DW         = 5;
  localparam int unsigned STREAM_LEN = 3 * N - 2;
  localparam int unsigned TW         = $clog2(STREAM_LEN);
  localparam int unsigned BW         = $clog2(N);

  typedef logic [DW-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    STREAM,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_bank.sv
// One NxN operand bank: beat k stores A row k and B column k; the read port
// returns the diagonally skewed left/top vectors for stream step t.
module systolic_feeder_bank
  import systolic_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [BW-1:0]         idx,
  input  logic [N-1:0][DW-1:0]  row,
  input  logic [N-1:0][DW-1:0]  col,
  input  logic [TW-1:0]         t,
  output logic [N-1:0][DW-1:0]  left,
  output logic [N-1:0][DW-1:0]  top
);

  // a_mem[k] = A row k, b_mem[k] = B column k, so both skews index [lane][t-lane]
  logic [N-1:0][DW-1:0] a_mem [N];
  logic [N-1:0][DW-1:0] b_mem [N];
  logic [BW-1:0]        k;
  int unsigned          tu;

  always_ff @(posedge clk) begin
    if (we) begin
      a_mem[idx] <= row;
      b_mem[idx] <= col;
    end
  end

  always_comb begin
    left = '0;
    top  = '0;
    k    = '0;
    tu   = 32'(t);
    for (int unsigned i = 0; i < N; i++) begin
      if (tu >= i && tu - i < N) begin
        k       = BW'(tu - i);
        left[i] = a_mem[i][k];
        top[i]  = b_mem[i][k];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 3x3 systolic array: load A/B, prime, skewed stream, done.
// Define SYSTOLIC_FEEDER_DBUF_EN for a second bank loaded while a run streams.
module systolic_feeder
  import systolic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][DW-1:0]  in_a,
  input  logic [N-1:0][DW-1:0]  in_b,
  output logic [N-1:0][DW-1:0]  left,
  output logic [N-1:0][DW-1:0]  top,
  output logic                  acc_clr,
  output logic                  busy,
  output logic                  done
);

  feeder_state_t        state;
  logic [BW-1:0]        beat_cnt;
  logic [TW-1:0]        t;
  logic [TW-1:0]        t_rd;
  logic                 accept;
  logic                 last_beat;
  logic [N-1:0][DW-1:0] rd_left;
  logic [N-1:0][DW-1:0] rd_top;

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_cnt == BW'(N - 1));
  // outputs are registered, so the bank is read one step ahead of t
  assign t_rd      = (state == STREAM) ? t + TW'(1) : '0;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
  logic                 wr_sel;
  logic                 shadow_full;
  logic [N-1:0][DW-1:0] b0_left, b0_top, b1_left, b1_top;

  systolic_feeder_bank u_bank0 (
    .clk (clk), .we (accept & ~wr_sel), .idx (beat_cnt), .row (in_a), .col (in_b),
    .t (t_rd), .left (b0_left), .top (b0_top)
  );
  systolic_feeder_bank u_bank1 (
    .clk (clk), .we (accept & wr_sel), .idx (beat_cnt), .row (in_a), .col (in_b),
    .t (t_rd), .left (b1_left), .top (b1_top)
  );

  // the read bank is always the one not being written
  assign rd_left = wr_sel ? b0_left : b1_left;
  assign rd_top  = wr_sel ? b0_top  : b1_top;

  always_comb begin
    in_ready = (state == IDLE) || (state == LOAD) || !shadow_full;
  end
`else
  systolic_feeder_bank u_bank (
    .clk (clk), .we (accept), .idx (beat_cnt), .row (in_a), .col (in_b),
    .t (t_rd), .left (rd_left), .top (rd_top)
  );

  always_comb begin
    in_ready = (state == IDLE) || (state == LOAD);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      t        <= '0;
      left     <= '0;
      top      <= '0;
      acc_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      wr_sel      <= 1'b0;
      shadow_full <= 1'b0;
`endif
    end else begin
      acc_clr <= 1'b0;
      done    <= 1'b0;
      left    <= '0;
      top     <= '0;
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
      if ((state == PRIME || state == STREAM) && accept && last_beat) shadow_full <= 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (accept && last_beat) begin
            state   <= PRIME;
            acc_clr <= 1'b1;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
            wr_sel  <= ~wr_sel;
`endif
          end
        end
        PRIME: begin
          state <= STREAM;
          t     <= '0;
          left  <= rd_left;
          top   <= rd_top;
        end
        STREAM: begin
          if (t == TW'(STREAM_LEN - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            t    <= t + TW'(1);
            left <= rd_left;
            top  <= rd_top;
          end
        end
        DONE: begin
`ifdef SYSTOLIC_FEEDER_DBUF_EN
          if (shadow_full || (accept && last_beat)) begin
            state       <= PRIME;
            acc_clr     <= 1'b1;
            wr_sel      <= ~wr_sel;
            shadow_full <= 1'b0;
          end else if (accept || beat_cnt != '0) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: skew, control pulses and a
// behavioural 3x3 array model checked against plain matrix multiplication.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int NC = 20;
  typedef int mat_t [3][3];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, acc_clr, busy, done;
  logic [N-1:0][DW-1:0] in_a = '0, in_b = '0, left, top;

  int total = 0;
  int bad = 0;

  logic [N-1:0][DW-1:0] cl [NC+1];
  logic [N-1:0][DW-1:0] ct [NC+1];
  logic ca [NC+1];
  logic cd [NC+1];
  logic cb [NC+1];
  logic cr [NC+1];

  always #5 clk = ~clk;

  systolic_feeder dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready),
    .in_a (in_a), .in_b (in_b), .left (left), .top (top),
    .acc_clr (acc_clr), .busy (busy), .done (done)
  );

  // cycle c counts from the edge that accepts beat 2 (c=1 is the first cycle after it)
  function automatic int exp_left(mat_t A, int i, int c);
    int tt = c - 2;
    if (tt < 0 || tt > 6 || tt - i < 0 || tt - i > 2) return 0;
    return A[i][tt - i];
  endfunction

  function automatic int exp_top(mat_t B, int j, int c);
    int tt = c - 2;
    if (tt < 0 || tt > 6 || tt - j < 0 || tt - j > 2) return 0;
    return B[tt - j][j];
  endfunction

  function automatic int mm(mat_t A, mat_t B, int i, int j);
    int s = 0;
    for (int k = 0; k < 3; k++) s += A[i][k] * B[k][j];
    return s;
  endfunction

  // PE(i,j) sees left[i] delayed j cycles and top[j] delayed i cycles
  function automatic int arr_c(int i, int j, int lo, int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) begin
      if (c - j >= lo && c - i >= lo)
        s += int'(cl[c - j][i]) * int'(ct[c - i][j]);
    end
    return s;
  endfunction

  task automatic rand_mat(output mat_t M);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) M[r][c] = int'($urandom_range(31, 0));
  endtask

  task automatic drive_beat(input mat_t A, input mat_t B, input int k);
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_a[j] = DW'(A[k][j]);
      in_b[j] = DW'(B[j][k]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_set(input mat_t A, input mat_t B);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) drive_beat(A, B, k);
  endtask

  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cl[c] = left; ct[c] = top;
      ca[c] = acc_clr; cd[c] = done; cb[c] = busy; cr[c] = in_ready;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (left !== '0) begin bad++; $display("FAIL reset_left got=%h want=0", left); end
    total++; if (top !== '0) begin bad++; $display("FAIL reset_top got=%h want=0", top); end
    total++; if (acc_clr !== 1'b0) begin bad++; $display("FAIL reset_acc_clr got=%b want=0", acc_clr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b1;
  endtask

  task automatic test_identity();
    mat_t A, B;
    int l0e [7] = '{1, 2, 3, 0, 0, 0, 0};
    int l2e [7] = '{0, 0, 7, 8, 9, 0, 0};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        A[r][c] = 3 * r + c + 1;
        B[r][c] = (r == c) ? 1 : 0;
      end
    load_set(A, B);
    capture(12);
    for (int tt = 0; tt < 7; tt++) begin
      total++; if (cl[tt + 2][0] !== DW'(l0e[tt])) begin bad++; $display("FAIL ident_left0 t=%0d got=%0d want=%0d", tt, cl[tt + 2][0], l0e[tt]); end
      total++; if (cl[tt + 2][2] !== DW'(l2e[tt])) begin bad++; $display("FAIL ident_left2 t=%0d got=%0d want=%0d", tt, cl[tt + 2][2], l2e[tt]); end
    end
    for (int c = 1; c <= 12; c++) begin
      total++; if (ca[c] !== (c == 1)) begin bad++; $display("FAIL ident_acc_clr c=%0d got=%b want=%b", c, ca[c], c == 1); end
      total++; if (cd[c] !== (c == 9)) begin bad++; $display("FAIL ident_done c=%0d got=%b want=%b", c, cd[c], c == 9); end
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        total++; if (arr_c(i, j, 1, 12) !== A[i][j]) begin bad++; $display("FAIL ident_c i=%0d j=%0d got=%0d want=%0d", i, j, arr_c(i, j, 1, 12), A[i][j]); end
      end
  endtask

  task automatic test_random();
    mat_t A, B;
    logic rdy_e;
    for (int run = 0; run < 4; run++) begin
      rand_mat(A); rand_mat(B);
      load_set(A, B);
      capture(12);
      for (int c = 1; c <= 12; c++) begin
`ifdef SYSTOLIC_FEEDER_DBUF_EN
        rdy_e = 1'b1;
`else
        rdy_e = (c >= 10);
`endif
        for (int i = 0; i < 3; i++) begin
          total++; if (cl[c][i] !== DW'(exp_left(A, i, c))) begin bad++; $display("FAIL rand_left run=%0d c=%0d i=%0d got=%0d want=%0d", run, c, i, cl[c][i], exp_left(A, i, c)); end
          total++; if (ct[c][i] !== DW'(exp_top(B, i, c))) begin bad++; $display("FAIL rand_top run=%0d c=%0d j=%0d got=%0d want=%0d", run, c, i, ct[c][i], exp_top(B, i, c)); end
        end
        total++; if (ca[c] !== (c == 1)) begin bad++; $display("FAIL rand_acc_clr c=%0d got=%b", c, ca[c]); end
        total++; if (cd[c] !== (c == 9)) begin bad++; $display("FAIL rand_done c=%0d got=%b", c, cd[c]); end
        total++; if (cb[c] !== (c <= 9)) begin bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, cb[c], c <= 9); end
        total++; if (cr[c] !== rdy_e) begin bad++; $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, cr[c], rdy_e); end
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          total++; if (arr_c(i, j, 1, 12) !== mm(A, B, i, j)) begin bad++; $display("FAIL rand_c i=%0d j=%0d got=%0d want=%0d", i, j, arr_c(i, j, 1, 12), mm(A, B, i, j)); end
        end
    end
  endtask

  task automatic test_full_width();
    mat_t A;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) A[r][c] = 31;
    load_set(A, A);
    capture(12);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        total++; if (arr_c(i, j, 1, 12) !== 2883) begin bad++; $display("FAIL full_width_c i=%0d j=%0d got=%0d want=2883", i, j, arr_c(i, j, 1, 12)); end
      end
  endtask

  task automatic test_gaps();
    mat_t A, B;
    rand_mat(A); rand_mat(B);
    @(posedge clk); #1;
    drive_beat(A, B, 0);
    for (int g = 0; g < 7; g++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy g=%0d got=%b want=1", g, busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL gap_in_ready g=%0d got=%b want=1", g, in_ready); end
      @(posedge clk); #1;
      if (g == 2) drive_beat(A, B, 1);
    end
    drive_beat(A, B, 2);
    capture(12);
    for (int c = 1; c <= 12; c++)
      for (int i = 0; i < 3; i++) begin
        total++; if (cl[c][i] !== DW'(exp_left(A, i, c))) begin bad++; $display("FAIL gap_left c=%0d i=%0d got=%0d want=%0d", c, i, cl[c][i], exp_left(A, i, c)); end
        total++; if (ct[c][i] !== DW'(exp_top(B, i, c))) begin bad++; $display("FAIL gap_top c=%0d j=%0d got=%0d want=%0d", c, i, ct[c][i], exp_top(B, i, c)); end
      end
    total++; if (cd[9] !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", cd[9]); end
  endtask

`ifndef SYSTOLIC_FEEDER_DBUF_EN
  task automatic test_hold();
    mat_t A, B;
    rand_mat(A); rand_mat(B);
    load_set(A, B);
    in_valid = 1'b1;
    in_a = DW'($urandom) == '0 ? '1 : {3{DW'($urandom)}};
    in_b = ~in_a;
    capture(9);
    in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      total++; if (cr[c] !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%b want=0", c, cr[c]); end
      for (int i = 0; i < 3; i++) begin
        total++; if (cl[c][i] !== DW'(exp_left(A, i, c))) begin bad++; $display("FAIL hold_left c=%0d i=%0d got=%0d want=%0d", c, i, cl[c][i], exp_left(A, i, c)); end
        total++; if (ct[c][i] !== DW'(exp_top(B, i, c))) begin bad++; $display("FAIL hold_top c=%0d j=%0d got=%0d want=%0d", c, i, ct[c][i], exp_top(B, i, c)); end
      end
    end
    total++; if (cd[9] !== 1'b1) begin bad++; $display("FAIL hold_done got=%b want=1", cd[9]); end
    load_set(A, B);
    capture(12);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        total++; if (arr_c(i, j, 1, 12) !== mm(A, B, i, j)) begin bad++; $display("FAIL hold_rerun_c i=%0d j=%0d got=%0d want=%0d", i, j, arr_c(i, j, 1, 12), mm(A, B, i, j)); end
      end
  endtask
`else
  task automatic test_dbuf();
    mat_t A1, B1, A2, B2;
    rand_mat(A1); rand_mat(B1); rand_mat(A2); rand_mat(B2);
    load_set(A1, B1);
    fork
      capture(20);
      for (int k = 0; k < 3; k++) drive_beat(A2, B2, k);
    join
    for (int c = 1; c <= 20; c++) begin
      total++; if (ca[c] !== (c == 1 || c == 10)) begin bad++; $display("FAIL dbuf_acc_clr c=%0d got=%b", c, ca[c]); end
      total++; if (cd[c] !== (c == 9 || c == 18)) begin bad++; $display("FAIL dbuf_done c=%0d got=%b", c, cd[c]); end
      if (c <= 18) begin
        total++; if (cb[c] !== 1'b1) begin bad++; $display("FAIL dbuf_busy c=%0d got=%b want=1", c, cb[c]); end
      end
    end
    for (int c = 11; c <= 18; c++)
      for (int i = 0; i < 3; i++) begin
        total++; if (cl[c][i] !== DW'(exp_left(A2, i, c - 9))) begin bad++; $display("FAIL dbuf_left2 c=%0d i=%0d got=%0d want=%0d", c, i, cl[c][i], exp_left(A2, i, c - 9)); end
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        total++; if (arr_c(i, j, 1, 9) !== mm(A1, B1, i, j)) begin bad++; $display("FAIL dbuf_c1 i=%0d j=%0d got=%0d want=%0d", i, j, arr_c(i, j, 1, 9), mm(A1, B1, i, j)); end
        total++; if (arr_c(i, j, 10, 18) !== mm(A2, B2, i, j)) begin bad++; $display("FAIL dbuf_c2 i=%0d j=%0d got=%0d want=%0d", i, j, arr_c(i, j, 10, 18), mm(A2, B2, i, j)); end
      end
  endtask
`endif

  task automatic test_reset_mid();
    mat_t A, B;
    int dones;
    rand_mat(A); rand_mat(B);
    load_set(A, B);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (left !== '0) begin bad++; $display("FAIL midrst_left got=%h want=0", left); end
    total++; if (top !== '0) begin bad++; $display("FAIL midrst_top got=%h want=0", top); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    rand_mat(A); rand_mat(B);
    load_set(A, B);
    capture(12);
    total++; if (cd[9] !== 1'b1) begin bad++; $display("FAIL midrst_rerun_done got=%b want=1", cd[9]); end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        total++; if (arr_c(i, j, 1, 12) !== mm(A, B, i, j)) begin bad++; $display("FAIL midrst_rerun_c i=%0d j=%0d got=%0d want=%0d", i, j, arr_c(i, j, 1, 12), mm(A, B, i, j)); end
      end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_random();
    test_full_width();
    test_gaps();
`ifndef SYSTOLIC_FEEDER_DBUF_EN
    test_hold();
`else
    test_dbuf();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder sitting directly upstream of the 3x3 systolic multiply array. Accepts matrix A (row-wise) and matrix B (column-wise) over a valid/ready load port, stores them, then drives the array's `left` and `top` buses with the diagonal skew the array needs. It also pulses an accumulator clear before each run and flags completion once the array's accumulators hold A×B.

## Interface
- `N`, 3: array dimension; fixed at 3 for this array.
- `DW`, 5: element width, matching the array operand width.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  load beat valid
- `in_ready`  out  1  feeder can accept a load beat
- `in_a`  in  [N-1:0][DW-1:0]  row k of A (element j = A[k][j])
- `in_b`  in  [N-1:0][DW-1:0]  column k of B (element i = B[i][k])
- `left`  out  [N-1:0][DW-1:0]  to array row inputs
- `top`  out  [N-1:0][DW-1:0]  to array column inputs
- `acc_clr`  out  1  one-cycle accumulator clear to array
- `busy`  out  1  high from first accepted beat until `done`
- `done`  out  1  one-cycle pulse: array results valid

## Operation
- Beat accepted when `in_valid && in_ready`. Beat k (k = 0..2) writes A row k and B column k. Beat counter wraps 2→0.
- FSM states:
  - IDLE: `in_ready=1`. First beat → LOAD.
  - LOAD: `in_ready=1`. Third beat → PRIME.
  - PRIME: one cycle, `acc_clr=1`, `in_ready=0`. Then → STREAM with t=0.
  - STREAM: t = 0..6 (3N-2 cycles). Then → DONE.
  - DONE: one cycle, `done=1`. Then → IDLE.
- Skew during STREAM cycle t:
  - `left[i] = A[i][t-i]` when 0 ≤ t-i ≤ 2, else 0.
  - `top[j] = B[t-j][j]` when 0 ≤ t-j ≤ 2, else 0.
  - Outputs are 0 in every state other than STREAM.
- Array PEs register right/bottom with one cycle of delay. PE(i,j) therefore sees A[i][k]·B[k][j] at t = k+i+j. The last product reaches PE(2,2) at t=6.
- `in_valid` while `in_ready=0` is ignored; no data is captured.
- No arithmetic is performed; elements pass through unmodified at DW bits.

## Timing
- Reset (`rst` low), asynchronous: state=IDLE, beat counter=0, t=0, `in_ready=1`, `left`/`top`=0, `acc_clr`=0, `busy`=0, `done`=0. Storage banks are not cleared.
- All outputs are registered except `in_ready`, which is decoded from state.
- Cycle count after the edge accepting beat 2:
  - PRIME: cycle 1.
  - STREAM t=0: cycle 2.
  - STREAM t=6: cycle 8.
  - `done`: cycle 9.
- Minimum cycles from first beat to `done`: 11.
- `rst` asserted mid-STREAM: outputs go to 0 immediately. The partial run is lost and no `done` is issued.
- Gaps in `in_valid` during LOAD are allowed: the FSM holds in LOAD, and the beat counter holds its value.

## Configuration
- `SYSTOLIC_FEEDER_DBUF_EN` defined:
  - Two storage banks.
  - `in_ready=1` also during PRIME, STREAM and DONE while the shadow bank is not full. Beats fill the shadow bank.
  - In DONE, if the shadow bank is full, swap banks and go directly to PRIME (back-to-back runs, one `done` per run). Otherwise go to IDLE, or to LOAD if the shadow bank is partially filled.
- Undefined:
  - One bank.
  - `in_ready=0` in PRIME, STREAM and DONE.

## Structure
- Package `systolic_pkg` holds:
  - `N`, `DW` and `STREAM_LEN = 3*N-2`.
  - The `feeder_state_t` enum {IDLE, LOAD, PRIME, STREAM, DONE}.
  - The element typedef `elem_t = logic [DW-1:0]`.
- Sub-module `systolic_feeder_bank`:
  - One N×N A/B storage bank with write port (beat index, row, col).
  - Skewed read port (t → left/top vectors).
  - Instantiated once, or twice under DBUF.

## Test plan
- Reset, then A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, three back-to-back beats. Expect:
  - `acc_clr` at cycle 1.
  - `left[0]` = 1,2,3,0,0,0,0 over t=0..6.
  - `left[2]` = 0,0,7,8,9,0,0 over t=0..6.
  - `done` at cycle 9.
  - The array model then reads C = A.
- A all 31, B all 31 → array model C elements = 2883. Confirms full-width pass-through.
- `in_valid` gaps (beats at cycles 0, 4, 9) → `busy` stays high and the skew pattern is unchanged relative to PRIME.
- `in_valid` held high during STREAM (macro undefined) → `in_ready=0` and the bank contents are unchanged. A second run yields the same C.
- `rst` low at STREAM t=3 → `left`/`top`/`busy` are 0 the same cycle, no `done`. A new full load then runs normally.
- With DBUF: the second operand set is loaded during the first STREAM → the second PRIME immediately follows the first `done`, giving two correct results 9 cycles apart.
